k423_wb_stage: RTL
==================

// Module: k423_wb_stage
// PURPOSE
//  Writeback stage; the writer side of the ID-stage regfile write and forward ports.
//  - Takes retiring instructions from MEM over a valid/ready handshake.
//  - Waits a variable time for the load response from data memory.
//  - Aligns and sign/zero-extends load data.
//  - Drives the regfile write port and the WB forward port.
//  - Flags a pending load so ID can stall on a load-use hazard.
// PARAMETERS
//  XLEN         32   data width
//  RIDX_W       5    register index width
//  RSP_TIMEOUT  255  max cycles spent in LDWAIT before abort (>=1)
// PORTS
//  clk_i                    in   1       clock
//  rst_i                    in   1       reset, synchronous, active-high
//  mem_vld_i                in   1       MEM offers an instruction
//  mem_rdy_o                out  1       WB can accept
//  mem_rd_vld_i             in   1       instruction writes rd
//  mem_rd_idx_i             in   RIDX_W  destination index
//  mem_rd_data_i            in   XLEN    ALU/CSR result (ignored for loads)
//  mem_load_i               in   1       instruction is a load
//  mem_load_size_i          in   2       0=byte 1=half 2=word (3 treated as word)
//  mem_load_uns_i           in   1       zero-extend (LBU/LHU)
//  mem_addr_lo_i            in   2       load address bits [1:0]
//  dmem_rsp_vld_i           in   1       load data valid (one-cycle pulse)
//  dmem_rsp_data_i          in   XLEN    raw aligned word from memory
//  wb_rd_vld_o              out  1       regfile write enable
//  wb_rd_idx_o              out  RIDX_W  regfile write index
//  wb_rd_data_o             out  XLEN    regfile write data
//  wb_fwd_rd_vld_o          out  1       forward valid (same cycle as write)
//  wb_fwd_rd_idx_o          out  RIDX_W  forward index
//  wb_fwd_rd_data_o         out  XLEN    forward data
//  wb_load_pending_o        out  1       load in LDWAIT; ID must stall if rs==pending idx
//  wb_load_pending_idx_o    out  RIDX_W  rd of the pending load
//  wb_retire_o              out  1       one-cycle pulse per completed instruction
//  wb_err_o                 out  1       one-cycle pulse on load timeout
// BEHAVIOUR
//  Reset:
//  - state=IDLE; all outputs 0 except mem_rdy_o=1.
//  - Held registers and the timeout counter cleared.
//  States:
//  - IDLE     nothing held.
//  - COMMIT   non-load held; write/retire this cycle.
//  - LDWAIT   load waiting for response.
//  - LDCOMMIT load data registered; write/retire this cycle.
//  Ready:
//  - mem_rdy_o = (state != LDWAIT).
//  - Accept = mem_vld_i & mem_rdy_o; back-to-back accepts are legal from COMMIT and LDCOMMIT.
//  Accept:
//  - Registers idx, data, size, uns and addr_lo.
//  - Next state is LDWAIT if mem_load_i, else COMMIT.
//  - With no accept, COMMIT and LDCOMMIT go to IDLE.
//  LDWAIT:
//  - wb_load_pending_o=1; the counter increments each cycle.
//  - dmem_rsp_vld_i: register the extended data, go to LDCOMMIT.
//  - Counter == RSP_TIMEOUT-1 with no response: wb_err_o pulse, no write, no retire, go to IDLE.
//  - A response and the timeout in the same cycle: the response wins.
//  dmem_rsp_vld_i outside LDWAIT is ignored, including a late response after a timeout.
//  Write/forward, combinational from the held registers:
//  - In COMMIT/LDCOMMIT: vld = held rd_vld & (idx != 0); fwd outputs mirror the write outputs.
//  - Latency: a non-load writes 1 cycle after accept.
//  - A load writes 1 cycle after dmem_rsp_vld_i.
//  - Data/idx outputs are 0 when vld=0.
//  Load extract, with sh = data >> (8*addr_lo):
//  - byte: sh[7:0].
//  - half: (data >> 16*addr_lo[1])[15:0]; addr_lo[0] ignored.
//  - word: whole word.
//  - Sign-extend unless uns.
//  wb_retire_o: pulses in COMMIT and LDCOMMIT, including when idx=0 or rd_vld=0.
//  Reset mid-LDWAIT: goes to IDLE, nothing is written, and any later response is ignored.
// TESTING
//  - ALU back-to-back: accept x5=0x11 then x6=0x22 on consecutive cycles -> writes on cycles +1 and +2, rdy stays 1.
//  - LB sign: load x7, addr_lo=3, rsp 0x80FF_FF00 after 4 cycles:
//    -> pending=1 with idx 7 and rdy=0 for 4 cycles.
//    -> x7=0xFFFF_FF80 written the cycle after rsp.
//  - LHU/LH: addr_lo=2, rsp 0x9234_5678:
//    -> LHU writes 0x0000_9234.
//    -> LH writes 0xFFFF_9234.
//  - x0 target: ALU rd=0 data=0xDEAD -> wb_rd_vld_o=0, wb_retire_o=1.
//  - Timeout with RSP_TIMEOUT=4, no rsp -> err pulse after 4 LDWAIT cycles, no write.
//    A rsp 2 cycles later -> ignored.
//  - Reset asserted in LDWAIT, rsp the next cycle -> outputs 0, state IDLE, no write.

Source files
------------

// File: rtl/k423_wb_stage_if.sv
// MEM -> WB retire handshake: one instruction per accepted beat, with the load attributes
// WB needs to finish it.
interface k423_wb_stage_if #(
    parameter int XLEN   = 32,
    parameter int RIDX_W = 5
);
    logic              vld;
    logic              rdy;
    logic              rd_vld;
    logic [RIDX_W-1:0] rd_idx;
    logic [XLEN-1:0]   rd_data;
    logic              load;
    logic [1:0]        load_size;
    logic              load_uns;
    logic [1:0]        addr_lo;

    modport master (output vld, rd_vld, rd_idx, rd_data, load, load_size, load_uns, addr_lo,
                    input  rdy);
    modport slave  (input  vld, rd_vld, rd_idx, rd_data, load, load_size, load_uns, addr_lo,
                    output rdy);
endinterface

// File: rtl/k423_wb_stage.sv
// Writeback stage: retires MEM instructions and waits for load data. It drives the regfile
// write/forward ports and exposes the pending load so that ID can detect load-use hazards.
module k423_wb_stage #(
    parameter int XLEN        = 32,
    parameter int RIDX_W      = 5,
    parameter int RSP_TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    k423_wb_stage_if.slave    mem,
    input  logic              dmem_rsp_vld_i,
    input  logic [XLEN-1:0]   dmem_rsp_data_i,
    output logic              wb_rd_vld_o,
    output logic [RIDX_W-1:0] wb_rd_idx_o,
    output logic [XLEN-1:0]   wb_rd_data_o,
    output logic              wb_fwd_rd_vld_o,
    output logic [RIDX_W-1:0] wb_fwd_rd_idx_o,
    output logic [XLEN-1:0]   wb_fwd_rd_data_o,
    output logic              wb_load_pending_o,
    output logic [RIDX_W-1:0] wb_load_pending_idx_o,
    output logic              wb_retire_o,
    output logic              wb_err_o
);
    localparam int CNT_W = (RSP_TIMEOUT < 2) ? 1 : $clog2(RSP_TIMEOUT);

    typedef enum logic [1:0] {IDLE, COMMIT, LDWAIT, LDCOMMIT} state_t;

    state_t            state_q, state_nx;
    logic              rd_vld_q, uns_q;
    logic [RIDX_W-1:0] idx_q;
    logic [XLEN-1:0]   data_q;
    logic [1:0]        size_q, addr_lo_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              accept, timeout_hit, commit, wr_vld;

    function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] d, input logic [1:0] sz,
                                                input logic uns, input logic [1:0] lo);
        logic [XLEN-1:0] sh_b, sh_h, r;
        sh_b = d >> {lo, 3'b000};
        sh_h = d >> {lo[1], 4'b0000};
        case (sz)
            2'd0:    r = uns ? XLEN'(sh_b[7:0])  : {{(XLEN-8){sh_b[7]}},   sh_b[7:0]};
            2'd1:    r = uns ? XLEN'(sh_h[15:0]) : {{(XLEN-16){sh_h[15]}}, sh_h[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    assign mem.rdy     = (state_q != LDWAIT);
    assign accept      = mem.vld & mem.rdy;
    assign timeout_hit = (cnt_q == CNT_W'(RSP_TIMEOUT - 1));

    always_comb begin
        state_nx = state_q;
        wb_err_o = 1'b0;
        case (state_q)
            IDLE, COMMIT, LDCOMMIT: begin
                if (accept) state_nx = mem.load ? LDWAIT : COMMIT;
                else        state_nx = IDLE;
            end
            LDWAIT: begin
                // A response arriving on the last allowed cycle still completes the load.
                if (dmem_rsp_vld_i) begin
                    state_nx = LDCOMMIT;
                end else if (timeout_hit) begin
                    state_nx = IDLE;
                    wb_err_o = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rd_vld_q  <= 1'b0;
            uns_q     <= 1'b0;
            idx_q     <= '0;
            data_q    <= '0;
            size_q    <= '0;
            addr_lo_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_nx;
            if (accept) begin
                rd_vld_q  <= mem.rd_vld;
                idx_q     <= mem.rd_idx;
                data_q    <= mem.rd_data;
                size_q    <= mem.load_size;
                uns_q     <= mem.load_uns;
                addr_lo_q <= mem.addr_lo;
                cnt_q     <= '0;
            end else if (state_q == LDWAIT) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (dmem_rsp_vld_i) data_q <= extract(dmem_rsp_data_i, size_q, uns_q, addr_lo_q);
            end
        end
    end

    assign commit = (state_q == COMMIT) || (state_q == LDCOMMIT);
    assign wr_vld = commit & rd_vld_q & (idx_q != '0);

    assign wb_rd_vld_o           = wr_vld;
    assign wb_rd_idx_o           = wr_vld ? idx_q  : '0;
    assign wb_rd_data_o          = wr_vld ? data_q : '0;
    assign wb_fwd_rd_vld_o       = wb_rd_vld_o;
    assign wb_fwd_rd_idx_o       = wb_rd_idx_o;
    assign wb_fwd_rd_data_o      = wb_rd_data_o;
    assign wb_load_pending_o     = (state_q == LDWAIT);
    assign wb_load_pending_idx_o = wb_load_pending_o ? idx_q : '0;
    assign wb_retire_o           = commit;
endmodule
